// File: rtl/dstack_spill_pkg.sv
// Shared definitions for the data-stack spill/fill controller.
// The movement codes are the same encoding the dstack itself decodes.
package dstack_spill_pkg;

    localparam logic [1:0] MOVE_NONE = 2'b00;
    localparam logic [1:0] MOVE_PUSH = 2'b01;
    localparam logic [1:0] MOVE_POP  = 2'b10;
    localparam logic [1:0] MOVE_POP2 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SPILL    = 2'd1,
        ST_FILL     = 2'd2,
        ST_FILL_OUT = 2'd3
    } state_e;

    // Number of elements a movement code removes from the stack.
    function automatic logic [1:0] pop_count(input logic [1:0] move);
        case (move)
            MOVE_POP:  pop_count = 2'd1;
            MOVE_POP2: pop_count = 2'd2;
            default:   pop_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/dstack_spill.sv
// Backing-store controller below the on-chip data stack. Words pushed off
// the bottom of a full stack are written to a memory spill region; after
// pops the bottom slot is refilled from that region so software sees a
// stack deeper than DEPTH. The core is stalled while memory is busy.
module dstack_spill #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 128,
    parameter int ADDR_WIDTH  = 16,
    parameter int SPILL_BASE  = 0,
    parameter int SPILL_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            movement,
    input  logic [WIDTH-1:0]      bottom,
    output logic                  stall,
    output logic                  fill_valid,
    output logic [WIDTH-1:0]      fill_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic                  mem_ack,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  spill_overflow,
    output logic                  underflow
);
    import dstack_spill_pkg::*;

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int SP_W  = $clog2(SPILL_WORDS + 1);

    state_e              state_q, state_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [1:0]          fills_q, fills_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic                is_push;
    logic [1:0]          pop_cnt;
    logic [OCC_W-1:0]    pop_n;
    logic                occ_full;
    logic                sp_full;
    logic                sp_empty;
    logic                pop_ok;
    logic [1:0]          fills_first;
    logic [ADDR_WIDTH-1:0] spill_addr;
    logic [ADDR_WIDTH-1:0] fill_addr;

    // Movement decode and occupancy predicates used by both FSM and datapath.
    assign is_push  = (movement == MOVE_PUSH);
    assign pop_cnt  = pop_count(movement);
    assign pop_n    = OCC_W'(pop_cnt);
    assign occ_full = (occ_q == OCC_W'(DEPTH));
    assign sp_full  = (sp_q == SP_W'(SPILL_WORDS));
    assign sp_empty = (sp_q == '0);
    assign pop_ok   = (pop_cnt != 2'd0) && (occ_q >= pop_n);

    // Only as many refills as there are spilled words: min(n, sp).
    assign fills_first = (pop_cnt == 2'd2 && sp_q == SP_W'(1)) ? 2'd1 : pop_cnt;

    // Spill writes the next free slot; fill reads the most recently spilled one.
    assign spill_addr = ADDR_WIDTH'(SPILL_BASE) + ADDR_WIDTH'(sp_q);
    assign fill_addr  = ADDR_WIDTH'(SPILL_BASE) + ADDR_WIDTH'(sp_q) - ADDR_WIDTH'(1);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples the pre-edge values regardless of block order.
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: movement is only looked at while idle.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (is_push && occ_full && !sp_full) begin
                    state_d = ST_SPILL;
                end else if (pop_ok && !sp_empty) begin
                    state_d = ST_FILL;
                end
            end
            ST_SPILL: begin
                if (mem_ack) state_d = ST_IDLE;
            end
            ST_FILL: begin
                if (mem_ack) state_d = ST_FILL_OUT;
            end
            ST_FILL_OUT: begin
                // sp_q was already decremented by the read; fills_q still
                // counts the word being delivered this cycle.
                if (fills_q > 2'd1 && !sp_empty) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Counter, data and fault-pulse updates.
    always_comb begin
        occ_d   = occ_q;
        sp_d    = sp_q;
        fills_d = fills_q;
        data_d  = data_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (is_push) begin
                    if (!occ_full) begin
                        occ_d = occ_q + OCC_W'(1);
                    end else if (!sp_full) begin
                        data_d = bottom;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (pop_cnt != 2'd0) begin
                    if (pop_ok) begin
                        occ_d = occ_q - pop_n;
                        if (!sp_empty) fills_d = fills_first;
                    end else begin
                        occ_d = '0;
                        unf_d = 1'b1;
                    end
                end
            end
            ST_SPILL: begin
                if (mem_ack) sp_d = sp_q + SP_W'(1);
            end
            ST_FILL: begin
                if (mem_ack) begin
                    data_d = mem_rdata;
                    sp_d   = sp_q - SP_W'(1);
                end
            end
            ST_FILL_OUT: begin
                occ_d   = occ_q + OCC_W'(1);
                fills_d = fills_q - 2'd1;
            end
        endcase
    end

    // Counters and fault pulses, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q   <= '0;
            sp_q    <= '0;
            fills_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            sp_q    <= sp_d;
            fills_q <= fills_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Spill/fill data register.
    always_ff @(posedge clk) begin
        // NOTE: left out of reset on purpose; it is only driven onto outputs
        // in SPILL or FILL_OUT, both of which load it first.
        data_q <= data_d;
    end

    // Outputs decoded from registered state only, so stall has no path from movement.
    always_comb begin
        stall      = (state_q != ST_IDLE);
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_valid = 1'b0;
        fill_data  = '0;
        unique case (state_q)
            ST_IDLE: begin
            end
            ST_SPILL: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = spill_addr;
                mem_wdata = data_q;
            end
            ST_FILL: begin
                mem_req  = 1'b1;
                mem_addr = fill_addr;
            end
            ST_FILL_OUT: begin
                fill_valid = 1'b1;
                fill_data  = data_q;
            end
        endcase
        spill_overflow = ovf_q;
        underflow      = unf_q;
    end

endmodule
